int_ctl: RTL and testbench



---
 rtl/int_pkg.sv | 18 +
 rtl/nmi_edge.sv | 27 ++
 rtl/int_ctl.sv | 158 +++++++++++++++
 tb/tb_int_ctl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/int_pkg.sv
// Shared types and constants for the 65C02 interrupt controller.
package int_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    SERVE = 2'd2
  } state_e;

  localparam logic [1:0] REG_MASK   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_ACTIVE = 2'd2;
  localparam logic [1:0] REG_SOFT   = 2'd3;

  localparam logic [15:0] NMI_VEC_DEF = 16'hFFFA;
  localparam logic [15:0] IRQ_VEC_DEF = 16'hFFFE;

endpackage

// File: rtl/nmi_edge.sv
// Two-flop synchroniser for the asynchronous nmi_n pin, followed by a
// falling-edge detector that emits a single-cycle pulse per high->low event.
module nmi_edge (
  input  logic clk,
  input  logic reset,
  input  logic nmi_n,
  output logic nmi_fall
);

  logic s1_q, s2_q, prev_q;

  // Idle level of nmi_n is high, so all stages reset to 1 (no false edge).
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      s1_q   <= nmi_n;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign nmi_fall = prev_q & ~s2_q;

endmodule

// File: rtl/int_ctl.sv
// Interrupt controller / sequencer for the microcoded 65C02 core.
// Merges masked level IRQs and an edge NMI into the core irq line, decides
// NMI vs IRQ at the entry acknowledge, and exposes mask/status/active/soft
// registers.
module int_ctl
  import int_pkg::*;
#(
  parameter int          NUM_SRC = 8,
  parameter logic [15:0] NMI_VEC = NMI_VEC_DEF,
  parameter logic [15:0] IRQ_VEC = IRQ_VEC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] src_irq,
  input  logic               nmi_n,
  input  logic               sync,
  input  logic               int_ack,
  output logic               irq,
  output logic [15:0]        vector,
  output logic               vec_valid,
  input  logic               reg_cs,
  input  logic               reg_we,
  input  logic [1:0]         reg_addr,
  input  logic [7:0]         reg_wdata,
  output logic [7:0]         reg_rdata
);

  // Lowest set index wins; returns 0 when nothing is set.
  function automatic logic [2:0] lowest_id(input logic [NUM_SRC-1:0] v);
    logic [2:0] id;
    id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) id = 3'(i);
    end
    return id;
  endfunction

  state_e             state_q, state_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] soft_q, soft_d;
  logic               nmi_pend_q, nmi_pend_d;
  logic               irq_q, irq_d;
  logic [15:0]        vector_q, vector_d;
  logic               vec_valid_q, vec_valid_d;
  logic               kind_nmi_q, kind_nmi_d;
  logic               id_valid_q, id_valid_d;
  logic [2:0]         id_q, id_d;
  logic [7:0]         rdata_q, rdata_d;

  logic               nmi_fall;
  logic [NUM_SRC-1:0] raw;
  logic [NUM_SRC-1:0] pend;
  logic               ack_take;
  logic               wr_en;

  nmi_edge u_nmi_edge (
    .clk      (clk),
    .reset    (reset),
    .nmi_n    (nmi_n),
    .nmi_fall (nmi_fall)
  );

  assign raw      = src_irq | soft_q;
  assign pend     = raw & mask_q;
  assign ack_take = int_ack & (state_q == ARMED);
  assign wr_en    = reg_cs & reg_we;

  // Request, pending-NMI and FSM next-state logic; an ack outside ARMED is ignored.
  always_comb begin
    irq_d       = (nmi_pend_q | (|pend)) & (state_q != SERVE);
    // A fresh edge landing on the clearing ack keeps the NMI pending.
    nmi_pend_d  = nmi_fall | (nmi_pend_q & ~ack_take);
    state_d     = state_q;
    vector_d    = vector_q;
    vec_valid_d = vec_valid_q;
    kind_nmi_d  = kind_nmi_q;
    id_valid_d  = id_valid_q;
    id_d        = id_q;
    unique case (state_q)
      IDLE: begin
        if (irq_d) state_d = ARMED;
      end
      ARMED: begin
        if (int_ack) begin
          state_d     = SERVE;
          kind_nmi_d  = nmi_pend_q;
          id_valid_d  = |pend;
          id_d        = lowest_id(pend);
          vector_d    = nmi_pend_q ? NMI_VEC : IRQ_VEC;
          vec_valid_d = 1'b1;
        end else if (!irq_d) begin
          state_d = IDLE;
        end
      end
      SERVE: begin
        // Handler's first opcode fetch ends the entry sequence.
        if (sync) begin
          state_d     = IDLE;
          vec_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Register writes and registered read mux.
  always_comb begin
    mask_d  = mask_q;
    soft_d  = soft_q;
    rdata_d = rdata_q;
    if (wr_en && reg_addr == REG_MASK) mask_d = reg_wdata[NUM_SRC-1:0];
    if (wr_en && reg_addr == REG_SOFT) soft_d = reg_wdata[NUM_SRC-1:0];
    if (reg_cs && !reg_we) begin
      unique case (reg_addr)
        REG_MASK:   rdata_d = 8'(mask_q);
        REG_STATUS: rdata_d = 8'(raw);
        REG_ACTIVE: rdata_d = {kind_nmi_q, id_valid_q, 3'b000, id_q};
        REG_SOFT:   rdata_d = 8'(soft_q);
        default:    rdata_d = 8'h00;
      endcase
    end
  end

  // State update; reset clears all pending and latched entry state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      soft_q      <= '0;
      nmi_pend_q  <= 1'b0;
      irq_q       <= 1'b0;
      vector_q    <= IRQ_VEC;
      vec_valid_q <= 1'b0;
      kind_nmi_q  <= 1'b0;
      id_valid_q  <= 1'b0;
      id_q        <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      soft_q      <= soft_d;
      nmi_pend_q  <= nmi_pend_d;
      irq_q       <= irq_d;
      vector_q    <= vector_d;
      vec_valid_q <= vec_valid_d;
      kind_nmi_q  <= kind_nmi_d;
      id_valid_q  <= id_valid_d;
      id_q        <= id_d;
      rdata_q     <= rdata_d;
    end
  end

  assign irq       = irq_q;
  assign vector    = vector_q;
  assign vec_valid = vec_valid_q;
  assign reg_rdata = rdata_q;

endmodule

// File: tb/tb_int_ctl.sv
// Directed bench for int_ctl: expected values are queued when stimulus is
// applied and popped/compared when the DUT output is sampled.
module tb_int_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  src_irq;
  logic        nmi_n;
  logic        sync;
  logic        int_ack;
  logic        irq;
  logic [15:0] vector;
  logic        vec_valid;
  logic        reg_cs;
  logic        reg_we;
  logic [1:0]  reg_addr;
  logic [7:0]  reg_wdata;
  logic [7:0]  reg_rdata;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;
  exp_t sb[$];

  int_ctl #(.NUM_SRC(8)) dut (
    .clk(clk), .reset(reset), .src_irq(src_irq), .nmi_n(nmi_n),
    .sync(sync), .int_ack(int_ack), .irq(irq), .vector(vector),
    .vec_valid(vec_valid), .reg_cs(reg_cs), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [15:0] val);
    sb.push_back('{tag, val});
  endtask

  task automatic pop_chk(input logic [15:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL sb_empty observed=%h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    push(tag, exp);
    pop_chk(obs);
  endtask

  task automatic reg_rd(input string tag, input logic [1:0] a, input logic [7:0] exp);
    reg_cs = 1'b1; reg_we = 1'b0; reg_addr = a;
    push(tag, {8'h00, exp});
    step();
    reg_cs = 1'b0;
    pop_chk({8'h00, reg_rdata});
  endtask

  task automatic reg_wr(input logic [1:0] a, input logic [7:0] d);
    reg_cs = 1'b1; reg_we = 1'b1; reg_addr = a; reg_wdata = d;
    step();
    reg_cs = 1'b0; reg_we = 1'b0;
  endtask

  initial begin
    reset = 1'b1; src_irq = '0; nmi_n = 1'b1; sync = 1'b0; int_ack = 1'b0;
    reg_cs = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
    step(); step();
    chk("rst_irq", {15'd0, irq}, 16'd0);
    chk("rst_vec", vector, 16'hFFFE);
    chk("rst_vvalid", {15'd0, vec_valid}, 16'd0);
    chk("rst_rdata", {8'd0, reg_rdata}, 16'd0);
    reset = 1'b0;
    step();
    reg_rd("rd_mask0", 2'd0, 8'h00);
    reg_rd("rd_status0", 2'd1, 8'h00);
    reg_rd("rd_active0", 2'd2, 8'h00);
    chk("idle_irq", {15'd0, irq}, 16'd0);

    // Level IRQ entry with priority to the lowest id
    reg_wr(2'd0, 8'h0C);
    reg_rd("rd_mask_c", 2'd0, 8'h0C);
    src_irq = 8'h08;
    chk("irq_not_yet", {15'd0, irq}, 16'd0);
    step();
    chk("irq_latency", {15'd0, irq}, 16'd1);
    src_irq = 8'h0C; int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("irq_vec", vector, 16'hFFFE);
    chk("irq_vvalid", {15'd0, vec_valid}, 16'd1);
    step();
    chk("serve_irq_low", {15'd0, irq}, 16'd0);
    reg_rd("active_id2", 2'd2, 8'h42);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("sync_vvalid", {15'd0, vec_valid}, 16'd0);
    chk("sync_irq_low", {15'd0, irq}, 16'd0);
    step();
    chk("irq_reassert", {15'd0, irq}, 16'd1);
    src_irq = 8'h00;
    step();
    chk("withdraw_irq", {15'd0, irq}, 16'd0);

    // NMI takes precedence; held-low nmi_n does not repeat
    src_irq = 8'h08; nmi_n = 1'b0;
    repeat (4) step();
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("nmi_vec", vector, 16'hFFFA);
    reg_rd("active_nmi", 2'd2, 8'hC3);
    sync = 1'b1; step(); sync = 1'b0;
    step();
    chk("irq_after_nmi", {15'd0, irq}, 16'd1);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("second_irq_vec", vector, 16'hFFFE);
    reg_rd("active_irq3", 2'd2, 8'h43);
    sync = 1'b1; step(); sync = 1'b0;
    step();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("no_repeat_nmi", vector, 16'hFFFE);
    sync = 1'b1; src_irq = 8'h00; nmi_n = 1'b1;
    step();
    sync = 1'b0;
    repeat (3) step();
    chk("quiet_irq", {15'd0, irq}, 16'd0);

    // New NMI edge coinciding with the NMI ack stays pending
    nmi_n = 1'b0;
    repeat (4) step();
    chk("nmi_only_irq", {15'd0, irq}, 16'd1);
    nmi_n = 1'b1;
    repeat (3) step();
    nmi_n = 1'b0;
    repeat (2) step();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("coinc_vec", vector, 16'hFFFA);
    sync = 1'b1; step(); sync = 1'b0;
    step();
    chk("coinc_irq", {15'd0, irq}, 16'd1);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("coinc_vec2", vector, 16'hFFFA);
    reg_rd("active_nmi_noid", 2'd2, 8'h80);
    sync = 1'b1; step(); sync = 1'b0;
    nmi_n = 1'b1;
    repeat (2) step();
    chk("coinc_quiet", {15'd0, irq}, 16'd0);

    // Withdrawn request, spurious ack, mask removal, raw status
    src_irq = 8'h04;
    step();
    chk("wd_irq_hi", {15'd0, irq}, 16'd1);
    src_irq = 8'h00;
    chk("wd_irq_reg", {15'd0, irq}, 16'd1);
    step();
    chk("wd_irq_lo", {15'd0, irq}, 16'd0);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("spur_vvalid", {15'd0, vec_valid}, 16'd0);
    reg_rd("spur_active", 2'd2, 8'h80);
    src_irq = 8'h04;
    step();
    chk("mask_irq_hi", {15'd0, irq}, 16'd1);
    reg_wr(2'd0, 8'h08);
    chk("mask_irq_lag", {15'd0, irq}, 16'd1);
    step();
    chk("mask_irq_drop", {15'd0, irq}, 16'd0);
    src_irq = 8'h05;
    reg_rd("status_raw", 2'd1, 8'h05);
    src_irq = 8'h00;

    // Soft request, then reset in SERVE
    reg_wr(2'd3, 8'h01);
    reg_wr(2'd0, 8'h01);
    reg_rd("status_soft", 2'd1, 8'h01);
    chk("soft_irq", {15'd0, irq}, 16'd1);
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("soft_vvalid", {15'd0, vec_valid}, 16'd1);
    reset = 1'b1;
    step();
    chk("rst2_irq", {15'd0, irq}, 16'd0);
    chk("rst2_vvalid", {15'd0, vec_valid}, 16'd0);
    chk("rst2_vec", vector, 16'hFFFE);
    reset = 1'b0;
    reg_rd("rst2_soft", 2'd3, 8'h00);
    reg_rd("rst2_mask", 2'd0, 8'h00);
    reg_rd("rst2_active", 2'd2, 8'h00);
    step();
    chk("rst2_idle_irq", {15'd0, irq}, 16'd0);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
